// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder for the MEM_OP stage.
//               Word-organised little-endian RAM with byte/half/word access,
//               sign/zero extension, and alignment/range/type checking.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int c_cnt_w = $clog2(LATENCY + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(LATENCY - 1);
    localparam int c_depth = 1 << ADDR_WIDTH;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic [3:0] c_lb  = 4'b1110;
    localparam logic [3:0] c_lh  = 4'b1010;
    localparam logic [3:0] c_lw  = 4'b1100;
    localparam logic [3:0] c_lbu = 4'b1111;
    localparam logic [3:0] c_lhu = 4'b1011;
    localparam logic [3:0] c_sb  = 4'b0110;
    localparam logic [3:0] c_sh  = 4'b0010;
    localparam logic [3:0] c_sw  = 4'b0100;

    localparam logic [1:0] c_sz_byte = 2'd0;
    localparam logic [1:0] c_sz_half = 2'd1;
    localparam logic [1:0] c_sz_word = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_type;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_error;

    // Contents survive rst; the array powers up cleared in simulation.
    logic [31:0] r_mem [c_depth] = '{default: '0};

    logic                  w_type_ok;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_unsigned;
    logic [1:0]            w_size;
    logic                  w_misaligned;
    logic                  w_oor;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_lane;
    logic [31:0]           w_rd_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;
    logic [3:0]            w_wmask;
    logic [31:0]           w_wdata_lanes;
    logic                  w_commit;
    logic                  w_we;

    always_comb begin
        w_type_ok  = 1'b1;
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_unsigned = 1'b0;
        w_size     = c_sz_word;
        case (r_type)
            c_lb:  begin w_is_load = 1'b1; w_size = c_sz_byte; end
            c_lbu: begin w_is_load = 1'b1; w_size = c_sz_byte; w_unsigned = 1'b1; end
            c_lh:  begin w_is_load = 1'b1; w_size = c_sz_half; end
            c_lhu: begin w_is_load = 1'b1; w_size = c_sz_half; w_unsigned = 1'b1; end
            c_lw:  begin w_is_load = 1'b1; w_size = c_sz_word; end
            c_sb:  begin w_is_store = 1'b1; w_size = c_sz_byte; end
            c_sh:  begin w_is_store = 1'b1; w_size = c_sz_half; end
            c_sw:  begin w_is_store = 1'b1; w_size = c_sz_word; end
            default: w_type_ok = 1'b0;
        endcase
    end

    generate
        if (ADDR_WIDTH + 2 < 32) begin : g_range
            assign w_oor = |r_addr[31:ADDR_WIDTH+2];
        end else begin : g_full_range
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_misaligned = ((w_size == c_sz_half) && r_addr[0]) ||
                          ((w_size == c_sz_word) && (r_addr[1:0] != 2'b00));
    assign w_err        = !w_type_ok || w_misaligned || w_oor;

    assign w_idx     = r_addr[ADDR_WIDTH+1:2];
    assign w_lane    = r_addr[1:0];
    assign w_rd_word = r_mem[w_idx];
    assign w_byte    = w_rd_word[{w_lane, 3'b000} +: 8];
    assign w_half    = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_comb begin
        w_load_data   = w_rd_word;
        w_wmask       = 4'b1111;
        w_wdata_lanes = r_wdata;
        case (w_size)
            c_sz_byte: begin
                w_load_data   = {{24{w_byte[7] & ~w_unsigned}}, w_byte};
                w_wmask       = 4'b0001 << w_lane;
                w_wdata_lanes = {4{r_wdata[7:0]}};
            end
            c_sz_half: begin
                w_load_data   = {{16{w_half[15] & ~w_unsigned}}, w_half};
                w_wmask       = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata_lanes = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // The access happens on the edge that leaves WAIT with the counter at 0.
    assign w_commit = (r_state == c_st_wait) && (r_cnt == '0);
    assign w_we     = w_commit && w_is_store && !w_err && !rst;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_type      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_type      <= req_type;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= c_cnt_init;
                        r_req_ready <= 1'b0;
                        r_state     <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (r_cnt == '0) begin
                        r_state     <= c_st_resp;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= w_err;
                        r_rsp_rdata <= (w_err || !w_is_load) ? 32'd0 : w_load_data;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        r_state     <= c_st_idle;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_error <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder (LATENCY 2 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam logic [3:0] c_lb  = 4'b1110;
    localparam logic [3:0] c_lh  = 4'b1010;
    localparam logic [3:0] c_lw  = 4'b1100;
    localparam logic [3:0] c_lbu = 4'b1111;
    localparam logic [3:0] c_lhu = 4'b1011;
    localparam logic [3:0] c_sb  = 4'b0110;
    localparam logic [3:0] c_sh  = 4'b0010;
    localparam logic [3:0] c_sw  = 4'b0100;
    localparam logic [3:0] c_nop = 4'b0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [1:0]  rsp_error;
    logic [3:0]  req_type  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_type(req_type[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
    );

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_type(req_type[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge; rsp_ready must be 1 for this instance.
    task automatic xact(input int s, input logic [3:0] t, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] o_rd,
                        output logic o_er, output int o_lat);
        chk($sformatf("req_ready_pre[%0d]", s), {31'd0, req_ready[s]}, 32'd1);
        req_type[s]  = t;
        req_addr[s]  = a;
        req_wdata[s] = wd;
        req_valid[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0;
        o_lat = 0;
        while (!rsp_valid[s] && o_lat < 20) begin
            @(negedge clk);
            o_lat++;
        end
        o_rd = rsp_rdata[s];
        o_er = rsp_error[s];
        @(negedge clk);
    endtask

    task automatic load_chk(input int s, input string tag, input logic [3:0] t,
                            input logic [31:0] a, input logic [31:0] exp, input int exp_lat);
        xact(s, t, a, 32'd0, rd, er, lat);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_err"}, {31'd0, er}, 32'd0);
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic err_chk(input string tag, input logic [3:0] t,
                           input logic [31:0] a, input logic [31:0] wd);
        xact(0, t, a, wd, rd, er, lat);
        chk({tag, "_err"}, {31'd0, er}, 32'd1);
        chk({tag, "_data"}, rd, 32'd0);
    endtask

    // Store is accepted, then reset lands before its commit edge.
    task automatic rst_drop(input int s, input logic [31:0] a, input logic [31:0] wd);
        req_type[s]  = c_sw;
        req_addr[s]  = a;
        req_wdata[s] = wd;
        req_valid[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("drop_rsp_valid[%0d]", s), {31'd0, rsp_valid[s]}, 32'd0);
        end
        chk($sformatf("drop_req_ready_in_rst[%0d]", s), {31'd0, req_ready[s]}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("drop_after_rsp_valid[%0d]", s), {31'd0, rsp_valid[s]}, 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_type[i]  = c_nop;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, req_ready[0]}, 32'd1);

        xact(0, c_sw, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("sw_lat", lat, 2);
        chk("sw_err", {31'd0, er}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_hs_req_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("sw_hs_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);

        load_chk(0, "lw10", c_lw, 32'h10, 32'hDEADBEEF, 2);
        chk("lw_hs_rdata_clear", rsp_rdata[0], 32'd0);
        load_chk(0, "lb13", c_lb, 32'h13, 32'hFFFFFFDE, 2);
        load_chk(0, "lbu13", c_lbu, 32'h13, 32'h000000DE, 2);
        load_chk(0, "lh12", c_lh, 32'h12, 32'hFFFFDEAD, 2);
        load_chk(0, "lhu10", c_lhu, 32'h10, 32'h0000BEEF, 2);

        xact(0, c_sb, 32'h11, 32'hAAAAAA55, rd, er, lat);
        chk("sb_err", {31'd0, er}, 32'd0);
        load_chk(0, "lw_after_sb", c_lw, 32'h10, 32'hDEAD55EF, 2);

        err_chk("lw_mis", c_lw, 32'h12, 32'd0);
        err_chk("sh_mis", c_sh, 32'h11, 32'h00001111);
        err_chk("nop", c_nop, 32'h10, 32'd0);
        err_chk("bad_type", 4'b0101, 32'h10, 32'hFFFFFFFF);
        load_chk(0, "lw_after_err", c_lw, 32'h10, 32'hDEAD55EF, 2);

        xact(0, c_sw, 32'h0, 32'hCAFEF00D, rd, er, lat);
        chk("sw0_err", {31'd0, er}, 32'd0);
        err_chk("sw_oor", c_sw, 32'h00001000, 32'h0BADBEEF);
        load_chk(0, "lw0_after_oor", c_lw, 32'h0, 32'hCAFEF00D, 2);

        rsp_ready[0] = 1'b0;
        req_type[0]  = c_lw;
        req_addr[0]  = 32'h10;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        lat = 0;
        while (!rsp_valid[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_lat", lat, 2);
        req_type[0]  = c_sw;
        req_wdata[0] = 32'h0;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            chk("bp_rdata", rsp_rdata[0], 32'hDEAD55EF);
            chk("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_rel_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("bp_rel_req_ready", {31'd0, req_ready[0]}, 32'd1);
        load_chk(0, "lw_after_bp", c_lw, 32'h10, 32'hDEAD55EF, 2);

        load_chk(0, "lw20_init", c_lw, 32'h20, 32'h0, 2);
        rst_drop(0, 32'h20, 32'h12345678);
        load_chk(0, "lw20_after_drop", c_lw, 32'h20, 32'h0, 2);

        xact(1, c_sw, 32'h20, 32'hA5A5A5A5, rd, er, lat);
        chk("l1_sw_lat", lat, 1);
        chk("l1_sw_err", {31'd0, er}, 32'd0);
        load_chk(1, "l1_lw20", c_lw, 32'h20, 32'hA5A5A5A5, 1);
        rst_drop(1, 32'h20, 32'h12345678);
        load_chk(1, "l1_lw20_after_drop", c_lw, 32'h20, 32'hA5A5A5A5, 1);
        load_chk(0, "l2_lw10_after_l1", c_lw, 32'h10, 32'hDEAD55EF, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
